// File: rtl/conv_load_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_load_sched_if                                                |
// | Burst-request and read-data channel between load scheduler and memory.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface conv_load_sched_if #(
   parameter int N_CONV_UNIT = 8,
   parameter int DATA_WIDTH  = 64,
   parameter int B_LEN       = 11
) ();

   localparam int c_unit_w = $clog2(N_CONV_UNIT);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_type;
   logic [c_unit_w-1:0]   req_unit;
   logic [B_LEN-1:0]      req_len;

   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_ready;

   modport master (
      output req_valid,
      input  req_ready,
      output req_type,
      output req_unit,
      output req_len,
      input  rd_valid,
      input  rd_data,
      output rd_ready
   );

   modport slave (
      input  req_valid,
      output req_ready,
      input  req_type,
      input  req_unit,
      input  req_len,
      output rd_valid,
      output rd_data,
      input  rd_ready
   );

endinterface
`default_nettype wire

// File: rtl/conv_load_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_load_sched                                                   |
// | Round-robin burst loader feeding weight/ftm buffers of the conv units.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module conv_load_sched #(
   parameter int N_CONV_UNIT     = 8,
   parameter int DATA_WIDTH      = 64,
   parameter int UNIT_BURSTS_WEI = 32,
   parameter int UNIT_BURSTS_FTM = 1024,
   parameter int B_LEN           = 11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CONV_UNIT-1:0] wb_full,
   input  logic [N_CONV_UNIT-1:0] fb_full,
   input  logic [N_CONV_UNIT-1:0] wb_suff,
   input  logic [N_CONV_UNIT-1:0] fb_suff,
   conv_load_sched_if.master      mem,
   output logic [DATA_WIDTH-1:0]  di,
   output logic [N_CONV_UNIT-1:0] wb_we,
   output logic [N_CONV_UNIT-1:0] fb_we,
   output logic                   pipe_en,
   output logic                   busy
);

   localparam int c_n_slot = 2 * N_CONV_UNIT;
   localparam int c_slot_w = $clog2(c_n_slot);
   localparam int c_unit_w = $clog2(N_CONV_UNIT);

   localparam logic [B_LEN-1:0] c_len_wei = B_LEN'(UNIT_BURSTS_WEI);
   localparam logic [B_LEN-1:0] c_len_ftm = B_LEN'(UNIT_BURSTS_FTM);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                 state_q,    state_d;
   logic [c_slot_w-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [B_LEN-1:0]       cnt_q,      cnt_d;
   logic                   req_type_q, req_type_d;
   logic [c_unit_w-1:0]    req_unit_q, req_unit_d;
   logic [B_LEN-1:0]       req_len_q,  req_len_d;
   logic [DATA_WIDTH-1:0]  di_q,       di_d;
   logic [N_CONV_UNIT-1:0] wb_we_q,    wb_we_d;
   logic [N_CONV_UNIT-1:0] fb_we_q,    fb_we_d;
   logic                   pipe_en_q;

   logic [c_n_slot-1:0]    w_elig;
   logic                   w_grant_found;
   logic [c_slot_w-1:0]    w_grant_slot;

   // Slot index arithmetic modulo the slot count (need not be a power of two).
   function automatic logic [c_slot_w-1:0] slot_add(
      input logic [c_slot_w-1:0] base,
      input int unsigned         off
   );
      logic [c_slot_w:0] sum;
      sum = {1'b0, base} + (c_slot_w+1)'(off);
      if (sum >= (c_slot_w+1)'(c_n_slot)) begin
         sum = sum - (c_slot_w+1)'(c_n_slot);
      end
      return sum[c_slot_w-1:0];
   endfunction

   generate
      for (genvar gu = 0; gu < N_CONV_UNIT; gu++) begin : g_elig
         assign w_elig[2*gu]   = ~wb_full[gu];
         assign w_elig[2*gu+1] = ~fb_full[gu];
      end
   endgenerate

   // Walk downward so the candidate closest to rr_ptr is the last one kept.
   always_comb begin
      logic [c_slot_w-1:0] cand;
      cand          = '0;
      w_grant_found = 1'b0;
      w_grant_slot  = '0;
      for (int i = c_n_slot - 1; i >= 0; i--) begin
         cand = slot_add(rr_ptr_q, i);
         if (w_elig[cand]) begin
            w_grant_found = 1'b1;
            w_grant_slot  = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      req_type_d = req_type_q;
      req_unit_d = req_unit_q;
      req_len_d  = req_len_q;
      di_d       = di_q;
      wb_we_d    = '0;
      fb_we_d    = '0;

      case (state_q)
         ST_IDLE: begin
            if (w_grant_found) begin
               state_d    = ST_REQ;
               rr_ptr_d   = slot_add(w_grant_slot, 1);
               req_type_d = w_grant_slot[0];
               req_unit_d = w_grant_slot[c_slot_w-1:1];
               req_len_d  = w_grant_slot[0] ? c_len_ftm : c_len_wei;
            end
         end
         ST_REQ: begin
            if (mem.req_ready) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            // Full flags are ignored here: the buffer already reserved the burst.
            if (mem.rd_valid) begin
               di_d = mem.rd_data;
               if (req_type_q) begin
                  fb_we_d[req_unit_q] = 1'b1;
               end else begin
                  wb_we_d[req_unit_q] = 1'b1;
               end
               cnt_d = cnt_q + B_LEN'(1);
               if (cnt_q == req_len_q - B_LEN'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         req_type_q <= 1'b0;
         req_unit_q <= '0;
         req_len_q  <= '0;
         di_q       <= '0;
         wb_we_q    <= '0;
         fb_we_q    <= '0;
         pipe_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         req_type_q <= req_type_d;
         req_unit_q <= req_unit_d;
         req_len_q  <= req_len_d;
         di_q       <= di_d;
         wb_we_q    <= wb_we_d;
         fb_we_q    <= fb_we_d;
         pipe_en_q  <= &(wb_suff & fb_suff);
      end
   end

   assign mem.req_valid = (state_q == ST_REQ);
   assign mem.req_type  = req_type_q;
   assign mem.req_unit  = req_unit_q;
   assign mem.req_len   = req_len_q;
   assign mem.rd_ready  = (state_q == ST_DATA);

   assign di      = di_q;
   assign wb_we   = wb_we_q;
   assign fb_we   = fb_we_q;
   assign pipe_en = pipe_en_q;
   assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_load_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_conv_load_sched                                                |
// | Directed/randomized bench with a slot-level round-robin reference model.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_conv_load_sched;

   localparam int N  = 8;
   localparam int DW = 64;
   localparam int UW = 32;
   localparam int UF = 1024;
   localparam int BL = 11;
   localparam int NS = 2 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  wb_full, fb_full, wb_suff, fb_suff;
   logic [DW-1:0] di;
   logic [N-1:0]  wb_we, fb_we;
   logic          pipe_en, busy;

   int checks   = 0;
   int errors   = 0;
   int model_rr = 0;

   conv_load_sched_if #(.N_CONV_UNIT(N), .DATA_WIDTH(DW), .B_LEN(BL)) mem ();

   conv_load_sched #(
      .N_CONV_UNIT    (N),
      .DATA_WIDTH     (DW),
      .UNIT_BURSTS_WEI(UW),
      .UNIT_BURSTS_FTM(UF),
      .B_LEN          (BL)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wb_full(wb_full),
      .fb_full(fb_full),
      .wb_suff(wb_suff),
      .fb_suff(fb_suff),
      .mem    (mem),
      .di     (di),
      .wb_we  (wb_we),
      .fb_we  (fb_we),
      .pipe_en(pipe_en),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // First non-full slot at or after the model pointer, -1 when none.
   function automatic int pick_slot();
      for (int k = 0; k < NS; k++) begin
         int s;
         s = (model_rr + k) % NS;
         if ((s % 2) == 1 ? !fb_full[s/2] : !wb_full[s/2]) return s;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},      64'(busy), 64'd0);
      check({tag, "_req_valid"}, 64'(mem.req_valid), 64'd0);
      check({tag, "_rd_ready"},  64'(mem.rd_ready), 64'd0);
      check({tag, "_wb_we"},     64'(wb_we), 64'd0);
      check({tag, "_fb_we"},     64'(fb_we), 64'd0);
      check({tag, "_di"},        64'(di), 64'd0);
      check({tag, "_pipe_en"},   64'(pipe_en), 64'd0);
      check({tag, "_req_type"},  64'(mem.req_type), 64'd0);
      check({tag, "_req_unit"},  64'(mem.req_unit), 64'd0);
      check({tag, "_req_len"},   64'(mem.req_len), 64'd0);
   endtask

   task automatic run_burst(input int stall, input int vpct, input bit shake, input int abort_at);
      int            s, len, beats, cyc;
      bit            v, beat;
      logic [DW-1:0] d;
      logic [N-1:0]  ew, ef;
      s = pick_slot();
      if (s < 0) return;
      len      = (s % 2 == 1) ? UF : UW;
      model_rr = (s + 1) % NS;
      beats    = 0;
      cyc      = 0;

      check("pre_busy", 64'(busy), 64'd0);
      step();
      check("grant_req_valid", 64'(mem.req_valid), 64'd1);
      check("grant_busy",      64'(busy), 64'd1);
      check("req_type",        64'(mem.req_type), 64'(s % 2));
      check("req_unit",        64'(mem.req_unit), 64'(s / 2));
      check("req_len",         64'(mem.req_len), 64'(len));
      check("req_rd_ready",    64'(mem.rd_ready), 64'd0);

      for (int i = 0; i < stall; i++) begin
         if (shake) begin
            wb_full = N'($urandom);
            fb_full = N'($urandom);
         end
         step();
         check("stall_req_valid", 64'(mem.req_valid), 64'd1);
         check("stall_req_type",  64'(mem.req_type), 64'(s % 2));
         check("stall_req_unit",  64'(mem.req_unit), 64'(s / 2));
         check("stall_req_len",   64'(mem.req_len), 64'(len));
      end

      mem.req_ready = 1'b1;
      step();
      mem.req_ready = 1'b0;
      check("data_req_valid", 64'(mem.req_valid), 64'd0);
      check("data_rd_ready",  64'(mem.rd_ready), 64'd1);

      while (beats < len && cyc < 8 * len + 100) begin
         v = ($urandom_range(99) < vpct);
         d = {$urandom, $urandom};
         mem.rd_valid = v;
         mem.rd_data  = d;
         if (shake) begin
            wb_full = N'($urandom);
            fb_full = N'($urandom);
         end
         beat = v && mem.rd_ready;
         step();
         cyc++;
         ew = '0;
         ef = '0;
         if (beat) begin
            if (s % 2 == 1) ef[s/2] = 1'b1;
            else            ew[s/2] = 1'b1;
            beats++;
            check("di", 64'(di), 64'(d));
         end
         check("wb_we", 64'(wb_we), 64'(ew));
         check("fb_we", 64'(fb_we), 64'(ef));
         if (abort_at >= 0 && beats == abort_at) begin
            rst = 1'b1;
            return;
         end
         if (beats < len) check("data_busy", 64'(busy), 64'd1);
      end
      mem.rd_valid = 1'b0;
      check("burst_beats",    64'(beats), 64'(len));
      check("end_busy",       64'(busy), 64'd0);
      check("end_rd_ready",   64'(mem.rd_ready), 64'd0);
      check("end_req_valid",  64'(mem.req_valid), 64'd0);
   endtask

   initial begin
      rst           = 1'b1;
      wb_full       = '1;
      fb_full       = '1;
      wb_suff       = '0;
      fb_suff       = '0;
      mem.req_ready = 1'b0;
      mem.rd_valid  = 1'b0;
      mem.rd_data   = '0;

      step();
      step();
      check_reset_outputs("reset");
      rst      = 1'b0;
      model_rr = 0;

      // Everything full: scheduler must stay idle.
      for (int i = 0; i < 20; i++) begin
         step();
         check("idle_req_valid", 64'(mem.req_valid), 64'd0);
         check("idle_busy",      64'(busy), 64'd0);
      end

      // Single weight burst to unit 3 with data every cycle.
      wb_full = ~8'h08;
      run_burst(0, 100, 1'b0, -1);
      wb_full = '1;
      fb_full = '1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_wei_idle", 64'(mem.req_valid), 64'd0);
      end

      // Backpressure: stalled request, sparse data, flags wiggling mid-burst.
      fb_full[2] = 1'b0;
      run_burst(5, 50, 1'b1, -1);
      wb_full = '1;
      fb_full = '1;

      // Pipeline enable follows suff bits one cycle later.
      wb_suff = '1;
      fb_suff = '1;
      check("pipe_en_before", 64'(pipe_en), 64'd0);
      step();
      check("pipe_en_on", 64'(pipe_en), 64'd1);
      fb_suff[5] = 1'b0;
      step();
      check("pipe_en_off", 64'(pipe_en), 64'd0);
      fb_suff = '1;
      step();
      check("pipe_en_back", 64'(pipe_en), 64'd1);

      // Reset after beat 10 of an ftm burst, remaining beats must be dropped.
      fb_full[0] = 1'b0;
      run_burst(0, 100, 1'b0, 10);
      model_rr = 0;
      step();
      check_reset_outputs("midrst");
      rst     = 1'b0;
      wb_full = '1;
      fb_full = '1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("ghost_wb_we",    64'(wb_we), 64'd0);
         check("ghost_fb_we",    64'(fb_we), 64'd0);
         check("ghost_rd_ready", 64'(mem.rd_ready), 64'd0);
      end
      mem.rd_valid = 1'b0;

      // Round-robin with everything eligible, starting from a reset pointer.
      for (int i = 0; i < NS + 2; i++) begin
         wb_full = '0;
         fb_full = '0;
         run_burst($urandom_range(2), $urandom_range(100, 40), 1'b1, -1);
      end

      // Random eligibility patterns against the model pointer.
      for (int i = 0; i < 10; i++) begin
         wb_full = N'($urandom);
         fb_full = N'($urandom);
         if (&wb_full && &fb_full) wb_full[$urandom_range(N-1)] = 1'b0;
         run_burst($urandom_range(3), $urandom_range(100, 40), 1'b1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
